// File: rtl/parser_rr_arbiter.sv
// Packet-level round-robin arbiter: grants one enabled port a whole head..tail packet,
// forwards it into the shared parser, then waits for the parser to cycle ready_out.
module parser_rr_arbiter #(
  parameter int NUM_PORT = 4,
  parameter int PORT_W   = 2,
  parameter int DW       = 134
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORT-1:0]    in_valid,
  input  logic [NUM_PORT*DW-1:0] in_data,
  output logic [NUM_PORT-1:0]    in_ready,
  input  logic [NUM_PORT-1:0]    port_enable,
  input  logic                   parser_ready,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [PORT_W-1:0]      grant_port,
  output logic                   err_gap,
  output logic                   err_frame,
  output logic [1:0]             dbg_state
);

  // Handshake: a beat on port i transfers on a clock edge where in_valid[i] & in_ready[i];
  // out_valid is a one-cycle registered strobe with no backpressure from the parser.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  state_e              state_q, state_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic [PORT_W-1:0]   grant_q, grant_d;
  logic                seen_low_q, seen_low_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                err_gap_q, err_gap_d;
  logic                err_frame_q, err_frame_d;

  logic [1:0]          beat_type [NUM_PORT];
  logic [NUM_PORT-1:0] req;
  logic [NUM_PORT-1:0] drop;
  logic [NUM_PORT-1:0] ready_c;
  logic                grant_found;
  logic [PORT_W-1:0]   grant_idx;

  always_comb begin
    req  = '0;
    drop = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      beat_type[i] = in_data[i*DW+DW-2 +: 2];
      req[i]  = in_valid[i] & port_enable[i] & (beat_type[i] == TYPE_HEAD);
      drop[i] = in_valid[i] & port_enable[i] & (beat_type[i] != TYPE_HEAD);
    end
  end

  // Search starts one past the pointer, so the last served port has lowest priority.
  always_comb begin
    logic [PORT_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_PORT; k++) begin
      idx = PORT_W'((int'(ptr_q) + k) % NUM_PORT);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    seen_low_d  = seen_low_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_gap_d   = 1'b0;
    err_frame_d = 1'b0;
    ready_c     = '0;
    case (state_q)
      S_IDLE: begin
        ready_c     = drop;
        err_frame_d = |drop;
        if (parser_ready && grant_found) begin
          ready_c[grant_idx] = 1'b1;
          out_valid_d        = 1'b1;
          out_data_d         = in_data[int'(grant_idx)*DW +: DW];
          grant_d            = grant_idx;
          seen_low_d         = 1'b0;
          state_d            = S_FWD;
        end
      end
      S_FWD: begin
        if (!parser_ready) seen_low_d = 1'b1;
        ready_c[grant_q] = 1'b1;
        if (in_valid[grant_q]) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data[int'(grant_q)*DW +: DW];
          if (beat_type[grant_q] == TYPE_TAIL) begin
            ptr_d   = grant_q;
            state_d = S_WAIT;
          end
        end else begin
          err_gap_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!parser_ready) seen_low_d = 1'b1;
        if (seen_low_q && parser_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= PORT_W'(NUM_PORT - 1);
      grant_q     <= '0;
      seen_low_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_gap_q   <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      seen_low_q  <= seen_low_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_gap_q   <= err_gap_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign in_ready   = reset ? ready_c : '0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign grant_port = grant_q;
  assign err_gap    = err_gap_q;
  assign err_frame  = err_frame_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_parser_rr_arbiter.sv
// Bench for parser_rr_arbiter: per-port beat queues feed the DUT, a parser model
// drives parser_ready, and forwarded beats are checked against an expected queue.
module tb_parser_rr_arbiter;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int DW = 134;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     in_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_ready;
  logic [NP-1:0]     port_enable;
  logic              parser_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [PW-1:0]     grant_port;
  logic              err_gap;
  logic              err_frame;
  logic [1:0]        dbg_state;

  parser_rr_arbiter #(.NUM_PORT(NP), .PORT_W(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .port_enable(port_enable), .parser_ready(parser_ready),
    .out_valid(out_valid), .out_data(out_data), .grant_port(grant_port),
    .err_gap(err_gap), .err_frame(err_frame), .dbg_state(dbg_state)
  );

  int tests_run = 0;
  int fails = 0;

  logic [PW+DW-1:0] exp_q[$];
  logic [DW:0]      pq[NP][$];

  bit            engine_on = 0;
  logic [NP-1:0] acc = '0;
  logic [NP-1:0] gap_shown = '0;
  logic [NP-1:0] rdy_seen = '0;
  int cyc = 0;
  int tail_delay = 1;
  int pcnt = 0;
  int rise_cyc = 0;
  int head_gap = 0;
  int gap_cnt = 0;
  int frame_cnt = 0;
  int bubbles = 0;
  int out_beats = 0;
  bit in_pkt = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_beat(input logic [1:0] t, input int port,
                                            input int pkt, input int idx);
    logic [DW-1:0] b;
    logic [31:0] p32, k32, i32;
    p32 = port; k32 = pkt; i32 = idx;
    b = '0;
    b[127:0]   = {$urandom, $urandom, $urandom, $urandom};
    b[131:124] = p32[7:0];
    b[123:116] = k32[7:0];
    b[115:108] = i32[7:0];
    b[133:132] = t;
    return b;
  endfunction

  // driver: queue one packet on a port; the first n_exp beats are expected at the output
  task automatic load_pkt(input int port, input int pkt, input int nb,
                          input int gap_at, input int gap_len, input int n_exp);
    for (int k = 0; k < nb; k++) begin
      logic [1:0]    t;
      logic [DW-1:0] b;
      logic [PW-1:0] pp;
      t = (k == 0) ? 2'b01 : ((k == nb - 1) ? 2'b10 : 2'b11);
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++) pq[port].push_back({1'b1, {DW{1'b0}}});
      b  = mk_beat(t, port, pkt, k);
      pp = PW'(port);
      pq[port].push_back({1'b0, b});
      if (k < n_exp) exp_q.push_back({pp, b});
    end
  endtask

  function automatic bit any_pending();
    bit r;
    r = (exp_q.size() != 0);
    for (int i = 0; i < NP; i++) if (pq[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (any_pending() && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d beats still outstanding, required 0", name, exp_q.size());
    end
    repeat (tail_delay + 4) @(posedge clk);
    #2;
  endtask

  // engine: monitor + scoreboard pop, parser model, port drivers
  initial begin
    logic [PW+DW-1:0] e;
    logic [DW:0]      dropb;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (engine_on) begin
        if (out_valid) begin
          out_beats++;
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got port %0d type %b, required no output",
                     grant_port, out_data[133:132]);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e[DW-1:0] || grant_port !== e[PW+DW-1:DW]) begin
              fails++;
              $display("FAIL beat_order: got port %0d data %h, required port %0d data %h",
                       grant_port, out_data, e[PW+DW-1:DW], e[DW-1:0]);
            end
          end
          if (out_data[133:132] == 2'b01) begin
            in_pkt = 1'b1;
            head_gap = cyc - rise_cyc;
            parser_ready = 1'b0;
            pcnt = 0;
          end
          if (out_data[133:132] == 2'b10) begin
            in_pkt = 1'b0;
            pcnt = tail_delay;
          end
        end else begin
          if (in_pkt) bubbles++;
          if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
              parser_ready = 1'b1;
              rise_cyc = cyc;
            end
          end
        end
        if (err_gap) gap_cnt++;
        if (err_frame) frame_cnt++;
        for (int i = 0; i < NP; i++)
          if ((acc[i] || gap_shown[i]) && pq[i].size() > 0) dropb = pq[i].pop_front();
        for (int i = 0; i < NP; i++) begin
          gap_shown[i] = 1'b0;
          if (pq[i].size() > 0) begin
            if (pq[i][0][DW]) begin
              in_valid[i]  = 1'b0;
              gap_shown[i] = 1'b1;
            end else begin
              in_valid[i] = 1'b1;
              in_data[i*DW +: DW] = pq[i][0][DW-1:0];
            end
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
      acc = in_valid & in_ready;
      rdy_seen = rdy_seen | in_ready;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    port_enable = 4'b1111;
    parser_ready = 1'b1;
    in_valid = 4'b1111;
    in_data = '0;
    for (int i = 0; i < NP; i++) in_data[i*DW+132 +: 2] = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    tests_run++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests_run++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    tests_run++; if (grant_port !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d, required 0", grant_port); end
    tests_run++; if (err_gap !== 1'b0 || err_frame !== 1'b0) begin fails++; $display("FAIL reset_err: got gap %b frame %b, required 0 0", err_gap, err_frame); end
    tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    in_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    tests_run++; if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL release_idle: got valid %b state %0d, required 0 0", out_valid, dbg_state); end
    engine_on = 1'b1;
  endtask

  task automatic test_rr_all();
    int b0, g0;
    b0 = bubbles; g0 = gap_cnt;
    for (int p = 0; p < NP; p++) load_pkt(p, 1, 4, -1, 0, 4);
    wait_drain("rr_all", 200);
    tests_run++; if (bubbles - b0 !== 0) begin fails++; $display("FAIL rr_all_contig: got %0d bubbles, required 0", bubbles - b0); end
    tests_run++; if (gap_cnt - g0 !== 0) begin fails++; $display("FAIL rr_all_err_gap: got %0d pulses, required 0", gap_cnt - g0); end
  endtask

  task automatic test_two_ports();
    int b0;
    b0 = bubbles;
    for (int r = 0; r < 3; r++) begin
      load_pkt(1, 10 + r, 2 + r, -1, 0, 2 + r);
      load_pkt(3, 20 + r, 3, -1, 0, 3);
    end
    wait_drain("two_ports", 300);
    tests_run++; if (bubbles - b0 !== 0) begin fails++; $display("FAIL two_ports_contig: got %0d bubbles, required 0", bubbles - b0); end
  endtask

  task automatic test_gap();
    int b0, g0;
    b0 = bubbles; g0 = gap_cnt;
    load_pkt(2, 30, 5, 2, 2, 5);
    wait_drain("gap", 200);
    tests_run++; if (gap_cnt - g0 !== 2) begin fails++; $display("FAIL gap_err_gap: got %0d pulses, required 2", gap_cnt - g0); end
    tests_run++; if (bubbles - b0 !== 2) begin fails++; $display("FAIL gap_bubbles: got %0d, required 2", bubbles - b0); end
  endtask

  task automatic test_parser_hold();
    tail_delay = 10;
    load_pkt(0, 40, 3, -1, 0, 3);
    load_pkt(1, 41, 4, -1, 0, 4);
    wait_drain("parser_hold", 300);
    tests_run++; if (head_gap !== 2) begin fails++; $display("FAIL parser_hold_latency: got %0d clks after rise, required 2", head_gap); end
    tail_delay = 1;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_enable_mask();
    int f0;
    @(negedge clk);
    port_enable = 4'b1011;
    rdy_seen = '0;
    load_pkt(2, 50, 3, -1, 0, 0);
    repeat (12) @(posedge clk);
    #2;
    tests_run++; if (rdy_seen[2] !== 1'b0) begin fails++; $display("FAIL mask_in_ready: got in_ready[2] seen %b, required 0", rdy_seen[2]); end
    tests_run++; if (grant_port === 2'd2) begin fails++; $display("FAIL mask_grant: got %0d, required not 2", grant_port); end
    f0 = frame_cnt;
    pq[0].push_back({1'b0, mk_beat(2'b11, 0, 51, 1)});
    repeat (5) @(posedge clk);
    #2;
    tests_run++; if (frame_cnt - f0 !== 1) begin fails++; $display("FAIL frame_pulse: got %0d pulses, required 1", frame_cnt - f0); end
    tests_run++; if (pq[0].size() !== 0) begin fails++; $display("FAIL frame_drop: got %0d beats left on port 0, required 0", pq[0].size()); end
    tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL frame_state: got %0d, required 0", dbg_state); end
    pq[2].delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    port_enable = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset_mid();
    int base, n;
    load_pkt(1, 60, 3, -1, 0, 3);
    wait_drain("pre_reset", 200);
    base = out_beats;
    load_pkt(2, 61, 6, -1, 0, 2);
    n = 0;
    while (out_beats - base < 2 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    tests_run++;
    if (out_beats - base < 2) begin fails++; $display("FAIL mid_reset_wait: got %0d beats, required 2", out_beats - base); end
    reset = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b, required 0", out_valid); end
    tests_run++; if (out_data !== '0) begin fails++; $display("FAIL mid_reset_data: got %h, required 0", out_data); end
    tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL mid_reset_state: got %0d, required 0", dbg_state); end
    tests_run++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL mid_reset_ready: got %b, required 0000", in_ready); end
    tests_run++; if (grant_port !== 2'd0) begin fails++; $display("FAIL mid_reset_grant: got %0d, required 0", grant_port); end
    for (int i = 0; i < NP; i++) pq[i].delete();
    exp_q.delete();
    in_valid = '0;
    acc = '0;
    in_pkt = 1'b0;
    pcnt = 0;
    parser_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    load_pkt(1, 62, 3, -1, 0, 3);
    load_pkt(3, 63, 3, -1, 0, 3);
    wait_drain("post_reset", 200);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = '0;
    in_data = '0;
    port_enable = 4'b1111;
    parser_ready = 1'b1;
    test_reset();
    test_rr_all();
    test_two_ports();
    test_gap();
    test_parser_hold();
    test_enable_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
